seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
Multi-cycle control unit for the 16-bit accumulator datapath (program counter, ROM, ALU, accumulator, register file, return stack). It replaces single-cycle decode with a FETCH/DECODE/EXECUTE state machine and handshakes with a ROM that may need wait states. It also guards stack overflow and underflow, supports single-step debugging, and reports halt and fault status.

Parameters:
OP_WIDTH, 8, opcode width; the ALU op bus has the same width.
FETCH_TIMEOUT, 15, maximum cycles in FETCH without rom_valid before a fault (1..255).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rom_valid  in  1  instr is valid this cycle
instr  in  OP_WIDTH  opcode field of the current ROM word
alu_zero  in  1  ALU zero flag
stack_full  in  1  return stack full
stack_empty  in  1  return stack empty
step_mode  in  1  1 = pause after every instruction
step  in  1  single-cycle pulse that releases a pause
rom_req  out  1  fetch request
pc_inc  out  1  PC += 1 this cycle
pc_load  out  1  PC loads jump address this cycle
jmp_sel  out  1  jump source: 0 = ROM data field, 1 = return address + 1
acu_en  out  1  accumulator load enable
rf_en  out  1  register file access enable
r_or_w  out  1  0 = read, 1 = write
ldi  out  1  operand mux selects the immediate
stack_push  out  1  push PC
stack_pop  out  1  pop return address
alu_op  out  OP_WIDTH  registered opcode (IR)
state  out  3  current state encoding
halted  out  1  HALT executed
fault  out  1  sticky fault
fault_code  out  2  0 = none, 1 = illegal opcode, 2 = stack error, 3 = fetch timeout

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, IR=0. All strobes, halted and fault are 0; fault_code=0; timeout counter=0. rom_req rises in the first cycle after reset is released.
- Only pc_inc, pc_load, acu_en, rf_en, r_or_w, ldi, stack_push, stack_pop and jmp_sel are combinational from state and IR. They are active only in EXECUTE and are otherwise 0.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, PAUSE=3, HALT=4, FAULT=5.
- FETCH:
  - rom_req=1.
  - On rom_valid: IR<=instr, counter cleared, go to DECODE.
  - Otherwise counter+1. When the counter reaches FETCH_TIMEOUT, go to FAULT with code 3.
- DECODE (1 cycle):
  - Illegal opcode -> FAULT, code 1.
  - Otherwise latch alu_zero into zflag and go to EXECUTE.
- Opcode map:
  - 0x00 NOP.
  - 0x01 LDI.
  - 0x02 LD.
  - 0x03 ST.
  - 0x10-0x1F ALU.
  - 0x20 JMP.
  - 0x21 JZ.
  - 0x22 CALL.
  - 0x23 RET.
  - 0xFF HALT.
  - All other opcodes are illegal.
- EXECUTE (1 cycle), per opcode:
  - NOP: pc_inc.
  - LDI: ldi, acu_en, pc_inc.
  - LD: rf_en, r_or_w=0, acu_en, pc_inc.
  - ALU: rf_en, r_or_w=0, acu_en, pc_inc.
  - ST: rf_en, r_or_w=1, pc_inc.
  - JMP: pc_load, jmp_sel=0.
  - JZ: if zflag then pc_load, else pc_inc.
  - CALL: if stack_full -> FAULT code 2 with no strobes; else stack_push, pc_load, jmp_sel=0.
  - RET: if stack_empty -> FAULT code 2 with no strobes; else stack_pop, pc_load, jmp_sel=1.
  - HALT: no strobes; go to HALT.
- After EXECUTE: go to PAUSE if step_mode=1, otherwise to FETCH.
- PAUSE: a step pulse -> FETCH. If step_mode drops to 0 -> FETCH.
- HALT and FAULT are terminal until reset. halted=1 in HALT; fault=1 and fault_code are held in FAULT.
- pc_inc and pc_load are never both 1. stack_push and stack_pop are never both 1.
- Latency: a zero-wait-state instruction takes 3 cycles (FETCH, DECODE, EXECUTE). Each ROM wait cycle adds 1.
- rom_valid outside FETCH is ignored. A step pulse outside PAUSE is ignored.
- Reset asserted mid-EXECUTE: strobes drop immediately (asynchronous) and state returns to FETCH.

Test Plan:
- rom_valid=1 always; program LDI, ALU 0x10, ST, HALT -> each instruction takes 3 cycles with the correct strobes; halted=1 at cycle 12; no pc_inc after HALT.
- JZ with alu_zero=1 at DECODE -> pc_load=1, pc_inc=0. Repeat with alu_zero=0 -> pc_inc=1, pc_load=0.
- CALL with stack_full=1 -> fault=1, fault_code=2, stack_push never asserted. RET with stack_empty=1 -> same fault, no stack_pop.
- rom_valid held low -> fault_code=3 after exactly 15 FETCH cycles. rom_valid after 3 wait cycles -> DECODE on cycle 4, no fault.
- Opcode 0x40 -> fault_code=1 after DECODE. With step_mode=1 -> state sits at PAUSE until a step pulse, then FETCH on the next cycle.
- Assert rst low mid-EXECUTE of a CALL -> stack_push drops in the same cycle; after release, state=FETCH and fault=0.

Source files
------------

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXECUTE control unit for the 16-bit
// accumulator datapath. It handshakes with a ROM that may insert wait states,
// decodes the opcode held in the instruction register, and issues one cycle of
// datapath strobes in EXECUTE. It also guards the return stack against
// overflow and underflow, supports single-step pausing, and reports sticky
// halt and fault status.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   rom_valid, instr    ROM handshake and opcode field (sampled in FETCH only)
//   alu_zero            ALU zero flag, latched in DECODE for JZ
//   stack_full/empty    return stack status, checked by CALL/RET in EXECUTE
//   step_mode, step     single-step enable and release pulse
//   rom_req             registered fetch request
//   pc_inc .. stack_pop datapath strobes, decoded from state and IR
//   alu_op              instruction register
//   state               current state encoding
//   halted, fault       sticky status flags
//   fault_code          0 none, 1 illegal opcode, 2 stack error, 3 fetch timeout
module seq_ctrl #(
  parameter int OP_WIDTH      = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_valid,
  input  logic [OP_WIDTH-1:0] instr,
  input  logic                alu_zero,
  input  logic                stack_full,
  input  logic                stack_empty,
  input  logic                step_mode,
  input  logic                step,
  output logic                rom_req,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                jmp_sel,
  output logic                acu_en,
  output logic                rf_en,
  output logic                r_or_w,
  output logic                ldi,
  output logic                stack_push,
  output logic                stack_pop,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_PAUSE   = 3'd3,
    S_HALT    = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam logic [OP_WIDTH-1:0] OP_NOP    = OP_WIDTH'(8'h00);
  localparam logic [OP_WIDTH-1:0] OP_LDI    = OP_WIDTH'(8'h01);
  localparam logic [OP_WIDTH-1:0] OP_LD     = OP_WIDTH'(8'h02);
  localparam logic [OP_WIDTH-1:0] OP_ST     = OP_WIDTH'(8'h03);
  localparam logic [OP_WIDTH-1:0] OP_ALU_LO = OP_WIDTH'(8'h10);
  localparam logic [OP_WIDTH-1:0] OP_ALU_HI = OP_WIDTH'(8'h1F);
  localparam logic [OP_WIDTH-1:0] OP_JMP    = OP_WIDTH'(8'h20);
  localparam logic [OP_WIDTH-1:0] OP_JZ     = OP_WIDTH'(8'h21);
  localparam logic [OP_WIDTH-1:0] OP_CALL   = OP_WIDTH'(8'h22);
  localparam logic [OP_WIDTH-1:0] OP_RET    = OP_WIDTH'(8'h23);
  localparam logic [OP_WIDTH-1:0] OP_HALT   = {OP_WIDTH{1'b1}};

  // Instruction classes produced by the decoder.
  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_LDI  = 4'd1;
  localparam logic [3:0] C_LD   = 4'd2;
  localparam logic [3:0] C_ST   = 4'd3;
  localparam logic [3:0] C_ALU  = 4'd4;
  localparam logic [3:0] C_JMP  = 4'd5;
  localparam logic [3:0] C_JZ   = 4'd6;
  localparam logic [3:0] C_CALL = 4'd7;
  localparam logic [3:0] C_RET  = 4'd8;
  localparam logic [3:0] C_HALT = 4'd9;
  localparam logic [3:0] C_ILL  = 4'd10;

  // Last counter value before the timeout fires: the counter holds the number
  // of FETCH cycles already spent without rom_valid.
  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e                state_q;
  logic [OP_WIDTH-1:0]   ir_q;
  logic                  zflag_q;
  logic [7:0]            cnt_q;
  logic                  rom_req_q;
  logic                  halted_q;
  logic                  fault_q;
  logic [1:0]            fault_code_q;
  logic [3:0]            op_cls_s;
  logic                  stack_err_s;

  function automatic logic [3:0] classify(input logic [OP_WIDTH-1:0] op);
    logic [3:0] cls;
    if (op == OP_NOP)                              cls = C_NOP;
    else if (op == OP_LDI)                         cls = C_LDI;
    else if (op == OP_LD)                          cls = C_LD;
    else if (op == OP_ST)                          cls = C_ST;
    else if ((op >= OP_ALU_LO) && (op <= OP_ALU_HI)) cls = C_ALU;
    else if (op == OP_JMP)                         cls = C_JMP;
    else if (op == OP_JZ)                          cls = C_JZ;
    else if (op == OP_CALL)                        cls = C_CALL;
    else if (op == OP_RET)                         cls = C_RET;
    else if (op == OP_HALT)                        cls = C_HALT;
    else                                           cls = C_ILL;
    return cls;
  endfunction

  assign op_cls_s    = classify(ir_q);
  // CALL into a full stack or RET from an empty one aborts with no strobes.
  assign stack_err_s = ((op_cls_s == C_CALL) && stack_full) ||
                       ((op_cls_s == C_RET)  && stack_empty);

  // Sequencer: state, instruction register, fetch timeout and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      ir_q         <= '0;
      zflag_q      <= 1'b0;
      cnt_q        <= 8'd0;
      rom_req_q    <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (rom_valid) begin
            ir_q      <= instr;
            cnt_q     <= 8'd0;
            rom_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end else if (cnt_q == TO_LAST) begin
            cnt_q        <= 8'd0;
            rom_req_q    <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= 2'd3;
            state_q      <= S_FAULT;
          end else begin
            cnt_q     <= cnt_q + 8'd1;
            rom_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (op_cls_s == C_ILL) begin
            fault_q      <= 1'b1;
            fault_code_q <= 2'd1;
            state_q      <= S_FAULT;
          end else begin
            zflag_q <= alu_zero;
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (op_cls_s == C_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (stack_err_s) begin
            fault_q      <= 1'b1;
            fault_code_q <= 2'd2;
            state_q      <= S_FAULT;
          end else if (step_mode) begin
            state_q <= S_PAUSE;
          end else begin
            rom_req_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_PAUSE: begin
          // Leaving step mode also releases the pause.
          if (step || !step_mode) begin
            rom_req_q <= 1'b1;
            state_q   <= S_FETCH;
          end else begin
            state_q <= S_PAUSE;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          rom_req_q <= 1'b1;
          state_q   <= S_FETCH;
        end
      endcase
    end
  end

  // Datapath strobes: decoded from IR, driven only during EXECUTE.
  always_comb begin
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    jmp_sel    = 1'b0;
    acu_en     = 1'b0;
    rf_en      = 1'b0;
    r_or_w     = 1'b0;
    ldi        = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    if (state_q == S_EXECUTE) begin
      case (op_cls_s)
        C_NOP: pc_inc = 1'b1;
        C_LDI: begin
          ldi    = 1'b1;
          acu_en = 1'b1;
          pc_inc = 1'b1;
        end
        C_LD, C_ALU: begin
          rf_en  = 1'b1;
          acu_en = 1'b1;
          pc_inc = 1'b1;
        end
        C_ST: begin
          rf_en  = 1'b1;
          r_or_w = 1'b1;
          pc_inc = 1'b1;
        end
        C_JMP: pc_load = 1'b1;
        C_JZ: begin
          if (zflag_q) pc_load = 1'b1;
          else         pc_inc  = 1'b1;
        end
        C_CALL: begin
          if (!stack_full) begin
            stack_push = 1'b1;
            pc_load    = 1'b1;
          end else begin
            stack_push = 1'b0;
          end
        end
        C_RET: begin
          if (!stack_empty) begin
            stack_pop = 1'b1;
            pc_load   = 1'b1;
            jmp_sel   = 1'b1;
          end else begin
            stack_pop = 1'b0;
          end
        end
        default: pc_inc = 1'b0;
      endcase
    end else begin
      pc_inc = 1'b0;
    end
  end

  assign rom_req    = rom_req_q;
  assign alu_op     = ir_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl. Expected EXECUTE outputs ({IR, strobes})
// are queued when an instruction is handed to the ROM port and compared by a
// monitor whenever the DUT is in EXECUTE.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rom_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       alu_zero = 1'b0;
  logic       stack_full = 1'b0;
  logic       stack_empty = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       rom_req, pc_inc, pc_load, jmp_sel, acu_en, rf_en, r_or_w, ldi;
  logic       stack_push, stack_pop, halted, fault;
  logic [7:0] alu_op;
  logic [2:0] state;
  logic [1:0] fault_code;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic push_seen = 1'b0;
  logic pop_seen  = 1'b0;
  logic [16:0] sb_q[$];

  // Strobe vectors: {pc_inc,pc_load,jmp_sel,acu_en,rf_en,r_or_w,ldi,push,pop}
  localparam logic [8:0] V_NONE = 9'b000000000;
  localparam logic [8:0] V_INC  = 9'b100000000;
  localparam logic [8:0] V_LDI  = 9'b100100100;
  localparam logic [8:0] V_RD   = 9'b100110000;
  localparam logic [8:0] V_ST   = 9'b100011000;
  localparam logic [8:0] V_JMP  = 9'b010000000;
  localparam logic [8:0] V_CALL = 9'b010000010;
  localparam logic [8:0] V_RET  = 9'b011000001;

  seq_ctrl #(.OP_WIDTH(8), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .rom_valid(rom_valid), .instr(instr),
    .alu_zero(alu_zero), .stack_full(stack_full), .stack_empty(stack_empty),
    .step_mode(step_mode), .step(step), .rom_req(rom_req), .pc_inc(pc_inc),
    .pc_load(pc_load), .jmp_sel(jmp_sel), .acu_en(acu_en), .rf_en(rf_en),
    .r_or_w(r_or_w), .ldi(ldi), .stack_push(stack_push), .stack_pop(stack_pop),
    .alu_op(alu_op), .state(state), .halted(halted), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {pc_inc, pc_load, jmp_sel, acu_en, rf_en, r_or_w, ldi, stack_push, stack_pop};
  endfunction

  // Scoreboard monitor: sample after each edge, compare EXECUTE outputs.
  always @(posedge clk) begin
    #1;
    if (stack_push) push_seen = 1'b1;
    if (stack_pop)  pop_seen  = 1'b1;
    if (pc_inc && pc_load) check_eq("inc_load_excl", 32'd1, 32'd0);
    if (rst && state == 3'd2) begin
      if (sb_q.size() == 0) check_eq("unexpected_exec", {24'd0, alu_op}, 32'hFFFF_FFFF);
      else check_eq("exec_out", {15'd0, alu_op, strobes()}, {15'd0, sb_q.pop_front()});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rom_valid = 1'b0; step_mode = 1'b0; step = 1'b0;
    stack_full = 1'b0; stack_empty = 1'b0; alu_zero = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_seen = 1'b0;
    pop_seen  = 1'b0;
  endtask

  // Hand one opcode to the ROM port at a FETCH negedge, queue the expected
  // EXECUTE outputs, and check the state after EXECUTE.
  task automatic run_instr(input logic [7:0] op, input logic z, input logic full,
                           input logic empty, input logic [8:0] exp_vec,
                           input logic [2:0] exp_after);
    check_eq("fetch_state", {29'd0, state}, 32'd0);
    instr = op; rom_valid = 1'b1;
    alu_zero = z; stack_full = full; stack_empty = empty;
    sb_q.push_back({op, exp_vec});
    @(negedge clk);
    rom_valid = 1'b0;
    check_eq("decode_state", {29'd0, state}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("after_exec", {29'd0, state}, {29'd0, exp_after});
  endtask

  initial begin
    int start;
    int n;
    #2 rst = 1'b0;
    @(negedge clk);
    // Reset state
    check_eq("rst_state", {29'd0, state}, 32'd0);
    check_eq("rst_outs", {21'd0, rom_req, halted, fault, fault_code, alu_op[5:0]}, 32'd0);
    check_eq("rst_strobes", {23'd0, strobes()}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rom_req_rise", {31'd0, rom_req}, 32'd1);

    // Program LDI, ALU, ST, HALT with zero wait states.
    start = cyc;
    run_instr(8'h01, 1'b0, 1'b0, 1'b0, V_LDI, 3'd0);
    run_instr(8'h10, 1'b0, 1'b0, 1'b0, V_RD,  3'd0);
    run_instr(8'h03, 1'b0, 1'b0, 1'b0, V_ST,  3'd0);
    run_instr(8'hFF, 1'b0, 1'b0, 1'b0, V_NONE, 3'd4);
    check_eq("halt_cycles", cyc - start, 32'd12);
    check_eq("halted", {31'd0, halted}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("halt_hold", {29'd0, state, pc_inc, pc_load}, {29'd4, 2'b00});

    // Branches, loads and stack ops on a healthy stack.
    do_reset();
    run_instr(8'h21, 1'b1, 1'b0, 1'b0, V_JMP,  3'd0);
    run_instr(8'h21, 1'b0, 1'b0, 1'b0, V_INC,  3'd0);
    run_instr(8'h20, 1'b0, 1'b0, 1'b0, V_JMP,  3'd0);
    run_instr(8'h02, 1'b0, 1'b0, 1'b0, V_RD,   3'd0);
    run_instr(8'h1F, 1'b0, 1'b0, 1'b0, V_RD,   3'd0);
    run_instr(8'h22, 1'b0, 1'b0, 1'b0, V_CALL, 3'd0);
    run_instr(8'h23, 1'b0, 1'b0, 1'b0, V_RET,  3'd0);
    run_instr(8'h00, 1'b0, 1'b0, 1'b0, V_INC,  3'd0);
    check_eq("no_fault", {29'd0, fault, fault_code}, 32'd0);

    // Stack overflow and underflow.
    do_reset();
    run_instr(8'h22, 1'b0, 1'b1, 1'b0, V_NONE, 3'd5);
    check_eq("call_full", {29'd0, fault, fault_code}, {29'd0, 1'b1, 2'd2});
    check_eq("no_push", {31'd0, push_seen}, 32'd0);
    do_reset();
    run_instr(8'h23, 1'b0, 1'b0, 1'b1, V_NONE, 3'd5);
    check_eq("ret_empty", {29'd0, fault, fault_code}, {29'd0, 1'b1, 2'd2});
    check_eq("no_pop", {31'd0, pop_seen}, 32'd0);

    // Fetch timeout: count edges until FETCH is left, bounded.
    do_reset();
    n = 0;
    while (state == 3'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_cycles", n, 32'd15);
    check_eq("timeout_code", {29'd0, state[0], fault_code}, {29'd0, 1'b1, 2'd3});

    // Three wait states, then a valid word: no fault.
    do_reset();
    repeat (3) @(negedge clk);
    check_eq("wait_fetch", {30'd0, rom_req, fault}, {30'd0, 1'b1, 1'b0});
    run_instr(8'h00, 1'b0, 1'b0, 1'b0, V_INC, 3'd0);
    check_eq("wait_no_fault", {31'd0, fault}, 32'd0);

    // Illegal opcode faults straight from DECODE.
    do_reset();
    instr = 8'h40; rom_valid = 1'b1;
    @(negedge clk);
    rom_valid = 1'b0;
    check_eq("ill_decode", {29'd0, state}, 32'd1);
    @(negedge clk);
    check_eq("ill_fault", {28'd0, state[2:1], fault, fault_code[1]}, {28'd0, 2'b10, 1'b1, 1'b0});
    check_eq("ill_code", {30'd0, fault_code}, 32'd1);

    // Single step: pause until a step pulse, or until step_mode drops.
    do_reset();
    step_mode = 1'b1;
    run_instr(8'h00, 1'b0, 1'b0, 1'b0, V_INC, 3'd3);
    repeat (4) @(negedge clk);
    check_eq("pause_hold", {29'd0, state}, 32'd3);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_eq("step_release", {29'd0, state}, 32'd0);
    run_instr(8'h01, 1'b0, 1'b0, 1'b0, V_LDI, 3'd3);
    step_mode = 1'b0;
    @(negedge clk);
    check_eq("mode_release", {29'd0, state}, 32'd0);

    // Reset asserted in the middle of a CALL's EXECUTE cycle.
    do_reset();
    instr = 8'h22; rom_valid = 1'b1;
    sb_q.push_back({8'h22, V_CALL});
    @(negedge clk);
    rom_valid = 1'b0;
    @(posedge clk);
    #2;
    check_eq("call_push", {31'd0, stack_push}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_push_drop", {31'd0, stack_push}, 32'd0);
    check_eq("rst_mid_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst", {28'd0, state, fault}, 32'd0);

    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
